vector_sequencer: RTL and testbench
===================================

# vector_sequencer

Parametrised, queued successor to the single-instruction vector decoder front end. It accepts APU requests into an in-order instruction queue and classifies each instruction. It then issues one beat per cycle (LANES elements per beat) with per-beat register addresses and a lane-enable mask, and returns one `apu_rvalid` per instruction in order. It sits between the core's APU interface and the per-beat control decode, register file and PE array.

## Interface
- `LANES`, default 4: elements per beat; power of 2, 1 to 16.
- `VL_W`, default 5: width of `vl`.
- `QDEPTH`, default 2: instruction queue entries; at least 1.
- `clk`  in  1  clock.
- `n_reset`  in  1  reset; asynchronous, active-low.
- `apu_req`  in  1  request.
- `apu_gnt`  out  1  grant; equals `!full`.
- `apu_operands`  in  3x32  [0],[1] scalar operands; [2] instruction word.
- `vl`  in  VL_W  current vector length (CSR).
- `stall`  in  1  downstream hold; freezes the current beat.
- `beat_valid`  out  1  beat presented this cycle.
- `first_beat`  out  1  first beat of an instruction.
- `last_beat`  out  1  last beat of an instruction.
- `instr`  out  32  instruction word of the beat.
- `scalar_operand1`  out  32  scalar operand [0] of the beat.
- `scalar_operand2`  out  32  scalar operand [1] of the beat.
- `vs1_addr`, `vs2_addr`, `vd_addr`  out  5 each  register addresses.
- `lane_en`  out  LANES  per-lane write enable.
- `csr_write`  out  1  vsetvli beat.
- `illegal`  out  1  unrecognised opcode.
- `apu_rvalid`  out  1  instruction completion pulse.
- `perf_beats`, `perf_stalls`  out  32 each  performance counters.

## Operation
- **Queue:**
  - Push on `apu_req & apu_gnt`.
  - Pop when `last_beat & !stall`.
  - Push and pop in the same cycle are both allowed when not full. There is no bypass when full.
- **Classification** (sub-module):
  - *Single-beat:* OP-V funct3=111 (vsetvli, sets `csr_write`); OP-V funct6=010000 (vmv.x.s); any unrecognised major opcode (sets `illegal`).
  - *Reduction:* OP-V funct3=010 with funct6 000000 or 000111; funct6 110001.
  - *Fixed-address:* LOAD-FP funct3=111.
  - *Stepped:* everything else.
- **Beats:** N = max(1, ceil(vl/LANES)), computed from `vl` sampled on the first beat and held for the rest of the instruction.
- **Addressing:**
  - Beat index b runs 0 to N-1.
  - Stepped: each address = field + b, mod 32 (wraps).
  - Reduction and fixed-address: addresses stay at the instruction field values.
- **Lane enables:**
  - Stepped and fixed-address: beats before the last enable all lanes. The last beat enables lanes [r-1:0], where r = vl mod LANES, or all lanes if r = 0.
  - Reduction: beats before the last are all-zero. The last beat enables lane 0 only.
  - Single-beat and `vl` = 0: `lane_en` = 0.
- **FSM:** IDLE -> ISSUE when the queue is non-empty. ISSUE stays while beats remain or the queue is non-empty; it returns to IDLE after the last beat pops with the queue empty.
- **Stall:** while `stall` is high, all beat outputs and the beat counter hold.
- **Reset** (asynchronous; also mid-instruction):
  - Queue flushed, FSM to IDLE, counters to 0, no `apu_rvalid` for flushed instructions.
  - All outputs 0 except `apu_gnt` = 1.

## Timing
- An instruction granted at edge k presents its first beat in cycle k+1 at the earliest (queue head is registered).
- Back-to-back: the next instruction's first beat is the cycle after the previous last beat. There are no bubbles.
- `apu_rvalid` is a registered 1-cycle pulse in the cycle after `last_beat & !stall`. Completions are in order.
- vsetvli: `vl` updates at the edge ending its beat, so the following instruction samples the new `vl`.

## Configuration
- `VSEQ_PERF_EN` defined:
  - `perf_beats` increments on each `beat_valid & !stall`.
  - `perf_stalls` increments on each `beat_valid & stall`.
  - Both saturate at 2^32-1 and reset to 0.
- Undefined: both counter outputs are tied to 0 and no counter flops exist.

## Structure
- `accelerator_pkg` gains `vseq_class_t` (SINGLE, STEPPED, REDUCTION, FIXED) and the funct6 constants used above. It reuses the existing `V_MAJOR_*` and `V_OP*` constants.
- Sub-module `vector_instr_class` is a combinational classifier: instruction word -> `vseq_class_t`, `csr_write`, `illegal`.

## Test plan
- LANES=4, `vl`=10, vadd.vv with vd=8, vs2=4, vs1=0:
  - 3 beats; addresses (8,4,0), (9,5,1), (10,6,2).
  - `lane_en` 1111, 1111, 0011.
  - `apu_rvalid` one cycle after the third beat.
- vredsum with `vl`=8:
  - 2 beats, fixed addresses.
  - `lane_en` 0000 then 0001.
- vsetvli then vadd issued back-to-back, with `vl` changing 4 -> 9:
  - vsetvli: 1 beat with `csr_write`.
  - vadd: 3 beats, computed from the new `vl`.
- QDEPTH=2 with 3 requests while `stall` is held high:
  - `apu_gnt` drops after 2 grants.
  - After `stall` is released: 3 in-order `apu_rvalid` pulses and no bubbles between instructions.
- vd=30, `vl`=12: addresses wrap 30, 31, 0.
- Unknown opcode: `illegal` high for 1 beat, `lane_en` 0, and `apu_rvalid` still pulses.
- Reset asserted mid-beat 2: all outputs 0, `apu_gnt` = 1, no `apu_rvalid`.
- With `VSEQ_PERF_EN`: 3 beats plus 2 stall cycles give `perf_beats`=3, `perf_stalls`=2.

Source files
------------

// File: rtl/accelerator_pkg.sv
// accelerator_pkg: opcodes, funct fields and shared types for the vector front end.
// Holds the major-opcode and funct3 encodings used by the classifier, the
// funct6 values that select single-beat and reduction handling, the
// sequencer class and FSM state types, and the instruction queue entry.
package accelerator_pkg;

   localparam logic [6:0] V_MAJOR_OP_V     = 7'b1010111;
   localparam logic [6:0] V_MAJOR_LOAD_FP  = 7'b0000111;
   localparam logic [6:0] V_MAJOR_STORE_FP = 7'b0100111;

   localparam logic [2:0] V_OPMVV          = 3'b010;
   localparam logic [2:0] V_OPCFG          = 3'b111;
   localparam logic [2:0] V_LOAD_FIXED_W   = 3'b111;

   localparam logic [5:0] V_F6_VREDSUM     = 6'b000000;
   localparam logic [5:0] V_F6_VREDMAX     = 6'b000111;
   localparam logic [5:0] V_F6_VWREDSUM    = 6'b110001;
   localparam logic [5:0] V_F6_VMV_X_S     = 6'b010000;

   typedef enum logic [1:0] {
      SINGLE,
      STEPPED,
      REDUCTION,
      FIXED
   } vseq_class_t;

   typedef enum logic {
      VSEQ_IDLE,
      VSEQ_ISSUE
   } vseq_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] op1;
      logic [31:0] op2;
   } vseq_entry_t;

endpackage

// File: rtl/vector_instr_class.sv
// vector_instr_class: combinational classifier for the vector sequencer.
// Maps an instruction word to its beat class, flags vsetvli as a CSR write
// and flags any major opcode outside OP-V / LOAD-FP / STORE-FP as illegal.
module vector_instr_class
   import accelerator_pkg::*;
(
   input  logic [31:0] instr,
   output vseq_class_t instr_class,
   output logic        csr_write,
   output logic        illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [5:0] funct6;
   logic       unused_fields;

   assign opcode        = instr[6:0];
   assign funct3        = instr[14:12];
   assign funct6        = instr[31:26];
   assign unused_fields = ^{instr[25:15], instr[11:7]};

   // Decode priority: vsetvli and vmv.x.s first, then reductions, else stepped.
   always_comb begin
      instr_class = STEPPED;
      csr_write   = 1'b0;
      illegal     = 1'b0;
      case (opcode)
         V_MAJOR_OP_V: begin
            if (funct3 == V_OPCFG) begin
               instr_class = SINGLE;
               csr_write   = 1'b1;
            end else if (funct6 == V_F6_VMV_X_S) begin
               instr_class = SINGLE;
            end else if ((funct3 == V_OPMVV &&
                          (funct6 == V_F6_VREDSUM || funct6 == V_F6_VREDMAX)) ||
                         funct6 == V_F6_VWREDSUM) begin
               instr_class = REDUCTION;
            end
         end
         V_MAJOR_LOAD_FP: begin
            if (funct3 == V_LOAD_FIXED_W) begin
               instr_class = FIXED;
            end
         end
         V_MAJOR_STORE_FP: begin
            instr_class = STEPPED;
         end
         default: begin
            instr_class = SINGLE;
            illegal     = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/vector_sequencer.sv
// vector_sequencer: queued APU front end that splits each vector instruction
// into LANES-wide beats with per-beat register addresses and lane enables.
// The queue head is the instruction currently issuing; it leaves the queue
// when its last beat is accepted. Optional feature macro: VSEQ_PERF_EN
// (beat/stall performance counters; tied to 0 when undefined).
module vector_sequencer
   import accelerator_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int VL_W   = 5,
   parameter int QDEPTH = 2
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             apu_req,
   output logic             apu_gnt,
   input  logic [31:0]      apu_operands [3],
   input  logic [VL_W-1:0]  vl,
   input  logic             stall,
   output logic             beat_valid,
   output logic             first_beat,
   output logic             last_beat,
   output logic [31:0]      instr,
   output logic [31:0]      scalar_operand1,
   output logic [31:0]      scalar_operand2,
   output logic [4:0]       vs1_addr,
   output logic [4:0]       vs2_addr,
   output logic [4:0]       vd_addr,
   output logic [LANES-1:0] lane_en,
   output logic             csr_write,
   output logic             illegal,
   output logic             apu_rvalid,
   output logic [31:0]      perf_beats,
   output logic [31:0]      perf_stalls
);

   localparam int PTR_W     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W     = $clog2(QDEPTH + 1);
   localparam int LANE_BITS = $clog2(LANES);

   vseq_entry_t       queue_mem [QDEPTH];
   vseq_entry_t       head;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;

   vseq_state_t       state;
   logic [VL_W:0]     beat_idx;
   logic [VL_W-1:0]   vl_lat;
   logic [VL_W-1:0]   eff_vl;
   logic [VL_W-1:0]   vl_rem;
   logic [VL_W:0]     vl_ceil;
   logic [VL_W:0]     n_beats;
   logic              is_first;
   logic              is_last;
   logic [4:0]        beat_step;
   logic [LANES-1:0]  last_mask;

   vseq_class_t       head_class;
   logic              head_csr;
   logic              head_illegal;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign apu_gnt = (count != CNT_W'(QDEPTH));
   assign push    = apu_req && apu_gnt;
   assign pop     = last_beat && !stall;
   assign head    = queue_mem[rd_ptr];

   vector_instr_class u_class (
      .instr       (head.instr),
      .instr_class (head_class),
      .csr_write   (head_csr),
      .illegal     (head_illegal)
   );

   // Queue bookkeeping; a full queue never accepts, even when popping.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (!push && pop) count <= count - CNT_W'(1);
      end
   end

   // Queue payload storage; contents are only visible while a beat is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         queue_mem[wr_ptr] <= '{instr: apu_operands[2],
                                op1:   apu_operands[0],
                                op2:   apu_operands[1]};
      end
   end

   // The first beat uses the live vl; later beats use the copy taken then.
   assign is_first  = (beat_idx == '0);
   assign eff_vl    = is_first ? vl : vl_lat;
   assign vl_ceil   = ({1'b0, eff_vl} + (VL_W+1)'(LANES - 1)) >> LANE_BITS;
   assign vl_rem    = eff_vl & VL_W'(LANES - 1);
   assign n_beats   = (head_class == SINGLE || vl_ceil == '0) ? (VL_W+1)'(1) : vl_ceil;
   assign is_last   = (beat_idx == n_beats - (VL_W+1)'(1));
   assign beat_step = 5'(beat_idx);
   assign beat_valid = (state == VSEQ_ISSUE) && (count != '0);

   // Last-beat mask: lanes below vl mod LANES, or every lane on an exact fit.
   always_comb begin
      last_mask = '0;
      for (int i = 0; i < LANES; i++) begin
         last_mask[i] = (vl_rem == '0) || (VL_W'(i) < vl_rem);
      end
   end

   // Beat outputs, all zero whenever no beat is presented.
   always_comb begin
      first_beat      = 1'b0;
      last_beat       = 1'b0;
      instr           = '0;
      scalar_operand1 = '0;
      scalar_operand2 = '0;
      vs1_addr        = '0;
      vs2_addr        = '0;
      vd_addr         = '0;
      lane_en         = '0;
      csr_write       = 1'b0;
      illegal         = 1'b0;
      if (beat_valid) begin
         first_beat      = is_first;
         last_beat       = is_last;
         instr           = head.instr;
         scalar_operand1 = head.op1;
         scalar_operand2 = head.op2;
         csr_write       = head_csr;
         illegal         = head_illegal;
         if (head_class == STEPPED) begin
            vs1_addr = head.instr[19:15] + beat_step;
            vs2_addr = head.instr[24:20] + beat_step;
            vd_addr  = head.instr[11:7]  + beat_step;
         end else begin
            vs1_addr = head.instr[19:15];
            vs2_addr = head.instr[24:20];
            vd_addr  = head.instr[11:7];
         end
         case (head_class)
            SINGLE:    lane_en = '0;
            REDUCTION: lane_en = is_last ? LANES'(1) : '0;
            default:   lane_en = is_last ? last_mask : '1;
         endcase
         if (eff_vl == '0) lane_en = '0;
      end
   end

   // Issue FSM with beat counter, vl capture and the completion pulse.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state      <= VSEQ_IDLE;
         beat_idx   <= '0;
         vl_lat     <= '0;
         apu_rvalid <= 1'b0;
      end else begin
         apu_rvalid <= pop;
         case (state)
            VSEQ_IDLE:  if (count != '0) state <= VSEQ_ISSUE;
            VSEQ_ISSUE: if (pop && !push && count == CNT_W'(1)) state <= VSEQ_IDLE;
            default:    state <= VSEQ_IDLE;
         endcase
         if (pop)                      beat_idx <= '0;
         else if (beat_valid && !stall) beat_idx <= beat_idx + (VL_W+1)'(1);
         if (beat_valid && is_first && !stall) vl_lat <= vl;
      end
   end

`ifdef VSEQ_PERF_EN
   logic [31:0] beat_count;
   logic [31:0] stall_count;

   // Saturating counters of accepted beats and stalled beat cycles.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         beat_count  <= '0;
         stall_count <= '0;
      end else begin
         if (beat_valid && !stall && beat_count != '1) beat_count  <= beat_count + 32'd1;
         if (beat_valid && stall && stall_count != '1) stall_count <= stall_count + 32'd1;
      end
   end

   assign perf_beats  = beat_count;
   assign perf_stalls = stall_count;
`else
   assign perf_beats  = '0;
   assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_vector_sequencer.sv
// tb_vector_sequencer: directed bench for vector_sequencer (LANES=4, VL_W=5,
// QDEPTH=2). Each scenario issues hand-encoded instructions and compares the
// beat stream cycle by cycle against hand-computed values.
module tb_vector_sequencer;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        apu_req = 1'b0;
   logic        apu_gnt;
   logic [31:0] apu_operands [3];
   logic [4:0]  vl = '0;
   logic        stall = 1'b0;
   logic        beat_valid, first_beat, last_beat;
   logic [31:0] instr, scalar_operand1, scalar_operand2;
   logic [4:0]  vs1_addr, vs2_addr, vd_addr;
   logic [3:0]  lane_en;
   logic        csr_write, illegal, apu_rvalid;
   logic [31:0] perf_beats, perf_stalls;

   int check_count = 0;
   int error_count = 0;

   vector_sequencer #(.LANES(4), .VL_W(5), .QDEPTH(2)) dut (
      .clk             (clk),
      .n_reset         (n_reset),
      .apu_req         (apu_req),
      .apu_gnt         (apu_gnt),
      .apu_operands    (apu_operands),
      .vl              (vl),
      .stall           (stall),
      .beat_valid      (beat_valid),
      .first_beat      (first_beat),
      .last_beat       (last_beat),
      .instr           (instr),
      .scalar_operand1 (scalar_operand1),
      .scalar_operand2 (scalar_operand2),
      .vs1_addr        (vs1_addr),
      .vs2_addr        (vs2_addr),
      .vd_addr         (vd_addr),
      .lane_en         (lane_en),
      .csr_write       (csr_write),
      .illegal         (illegal),
      .apu_rvalid      (apu_rvalid),
      .perf_beats      (perf_beats),
      .perf_stalls     (perf_stalls)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Hard stop in case a scenario loses sync with the DUT.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] opv(input logic [5:0] f6, input logic [2:0] f3,
                                        input logic [4:0] vd, input logic [4:0] vs2,
                                        input logic [4:0] vs1);
      return {f6, 1'b1, vs2, vs1, f3, vd, 7'b1010111};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Presents one request and returns 1 time unit after the granting edge.
   task automatic applyStimulus(input logic [31:0] word, input logic [31:0] op1,
                                input logic [31:0] op2);
      int waited = 0;
      apu_operands[0] = op1;
      apu_operands[1] = op2;
      apu_operands[2] = word;
      apu_req = 1'b1;
      while (!apu_gnt && waited < 20) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (!apu_gnt) checkOutput("grant_timeout", 32'(apu_gnt), 32'd1);
      @(posedge clk);
      #1 apu_req = 1'b0;
   endtask

   // Waits for the next falling edge and compares the whole beat bundle.
   task automatic expectBeat(input string tag, input logic v, input logic f,
                             input logic l, input logic c, input logic il,
                             input logic rv, input logic [4:0] vd,
                             input logic [4:0] s2, input logic [4:0] s1,
                             input logic [3:0] lanes);
      @(negedge clk);
      checkOutput(tag,
         32'({beat_valid, first_beat, last_beat, csr_write, illegal, apu_rvalid,
              vd_addr, vs2_addr, vs1_addr, lane_en}),
         32'({v, f, l, c, il, rv, vd, s2, s1, lanes}));
   endtask

   task automatic expectIdle(input string tag, input logic rv);
      expectBeat(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rv, 5'd0, 5'd0, 5'd0, 4'b0000);
   endtask

   initial begin
      logic [31:0] word;
      int          busy_seen;

      apu_operands = '{default: '0};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      expectIdle("reset_beat", 1'b0);
      checkOutput("reset_gnt", 32'(apu_gnt), 32'd1);
      checkOutput("reset_instr", instr, 32'd0);
      checkOutput("reset_perf", perf_beats | perf_stalls, 32'd0);
      @(posedge clk);
      #1 n_reset = 1'b1;

      // vadd.vv vd=8 vs2=4 vs1=0, vl=10: three stepped beats
      vl = 5'd10;
      word = opv(6'b000000, 3'b000, 5'd8, 5'd4, 5'd0);
      applyStimulus(word, 32'h1111_0000, 32'h2222_0000);
      expectIdle("vadd_wait", 1'b0);
      expectBeat("vadd_b0", 1, 1, 0, 0, 0, 0, 5'd8, 5'd4, 5'd0, 4'b1111);
      checkOutput("vadd_instr", instr, word);
      checkOutput("vadd_op1", scalar_operand1, 32'h1111_0000);
      checkOutput("vadd_op2", scalar_operand2, 32'h2222_0000);
      expectBeat("vadd_b1", 1, 0, 0, 0, 0, 0, 5'd9, 5'd5, 5'd1, 4'b1111);
      expectBeat("vadd_b2", 1, 0, 1, 0, 0, 0, 5'd10, 5'd6, 5'd2, 4'b0011);
      expectIdle("vadd_rvalid", 1'b1);
      expectIdle("vadd_after", 1'b0);

      // vredsum.vs vd=3 vs2=5 vs1=7, vl=8: two fixed-address beats
      vl = 5'd8;
      applyStimulus(opv(6'b000000, 3'b010, 5'd3, 5'd5, 5'd7), 32'd0, 32'd0);
      expectIdle("vred_wait", 1'b0);
      expectBeat("vred_b0", 1, 1, 0, 0, 0, 0, 5'd3, 5'd5, 5'd7, 4'b0000);
      expectBeat("vred_b1", 1, 0, 1, 0, 0, 0, 5'd3, 5'd5, 5'd7, 4'b0001);
      expectIdle("vred_rvalid", 1'b1);

      // vsetvli then vadd back to back; vl goes 4 -> 9 at the vsetvli edge
      vl = 5'd4;
      applyStimulus({1'b0, 11'h0d0, 5'd1, 3'b111, 5'd2, 7'b1010111}, 32'd9, 32'd0);
      applyStimulus(opv(6'b000000, 3'b000, 5'd1, 5'd2, 5'd3), 32'd0, 32'd0);
      expectBeat("vset_b0", 1, 1, 1, 1, 0, 0, 5'd2, 5'd16, 5'd1, 4'b0000);
      @(posedge clk);
      #1 vl = 5'd9;
      expectBeat("vnew_b0", 1, 1, 0, 0, 0, 1, 5'd1, 5'd2, 5'd3, 4'b1111);
      expectBeat("vnew_b1", 1, 0, 0, 0, 0, 0, 5'd2, 5'd3, 5'd4, 4'b1111);
      expectBeat("vnew_b2", 1, 0, 1, 0, 0, 0, 5'd3, 5'd4, 5'd5, 4'b0001);
      expectIdle("vnew_rvalid", 1'b1);

      // Three single-beat requests under stall with a two-entry queue
      vl = 5'd4;
      stall = 1'b1;
      applyStimulus(opv(6'b000000, 3'b000, 5'd10, 5'd0, 5'd0), 32'd0, 32'd0);
      applyStimulus(opv(6'b000000, 3'b000, 5'd11, 5'd0, 5'd0), 32'd0, 32'd0);
      apu_operands[2] = opv(6'b000000, 3'b000, 5'd12, 5'd0, 5'd0);
      apu_req = 1'b1;
      expectBeat("stall_a", 1, 1, 1, 0, 0, 0, 5'd10, 5'd0, 5'd0, 4'b1111);
      checkOutput("stall_gnt_full", 32'(apu_gnt), 32'd0);
      expectBeat("stall_hold1", 1, 1, 1, 0, 0, 0, 5'd10, 5'd0, 5'd0, 4'b1111);
      expectBeat("stall_hold2", 1, 1, 1, 0, 0, 0, 5'd10, 5'd0, 5'd0, 4'b1111);
      @(posedge clk);
      #1 stall = 1'b0;
      expectBeat("q_a", 1, 1, 1, 0, 0, 0, 5'd10, 5'd0, 5'd0, 4'b1111);
      checkOutput("q_gnt_still_full", 32'(apu_gnt), 32'd0);
      expectBeat("q_b", 1, 1, 1, 0, 0, 1, 5'd11, 5'd0, 5'd0, 4'b1111);
      checkOutput("q_gnt_open", 32'(apu_gnt), 32'd1);
      @(posedge clk);
      #1 apu_req = 1'b0;
      expectBeat("q_c", 1, 1, 1, 0, 0, 1, 5'd12, 5'd0, 5'd0, 4'b1111);
      expectIdle("q_rvalid_c", 1'b1);
      expectIdle("q_done", 1'b0);

      // Stepped addresses wrap modulo 32: vd=30, vl=12
      vl = 5'd12;
      applyStimulus(opv(6'b000000, 3'b000, 5'd30, 5'd0, 5'd0), 32'd0, 32'd0);
      expectIdle("wrap_wait", 1'b0);
      expectBeat("wrap_b0", 1, 1, 0, 0, 0, 0, 5'd30, 5'd0, 5'd0, 4'b1111);
      expectBeat("wrap_b1", 1, 0, 0, 0, 0, 0, 5'd31, 5'd1, 5'd1, 4'b1111);
      expectBeat("wrap_b2", 1, 0, 1, 0, 0, 0, 5'd0, 5'd2, 5'd2, 4'b1111);
      expectIdle("wrap_rvalid", 1'b1);

      // Unknown major opcode: single illegal beat, still completes
      applyStimulus({7'd0, 5'd3, 5'd4, 3'b000, 5'd5, 7'b0110011}, 32'd0, 32'd0);
      expectIdle("ill_wait", 1'b0);
      expectBeat("ill_b0", 1, 1, 1, 0, 1, 0, 5'd5, 5'd3, 5'd4, 4'b0000);
      expectIdle("ill_rvalid", 1'b1);

      // Asynchronous reset during the second beat
      applyStimulus(opv(6'b000000, 3'b000, 5'd20, 5'd1, 5'd2), 32'h55, 32'h66);
      expectIdle("rst_wait", 1'b0);
      expectBeat("rst_b0", 1, 1, 0, 0, 0, 0, 5'd20, 5'd1, 5'd2, 4'b1111);
      expectBeat("rst_b1", 1, 0, 0, 0, 0, 0, 5'd21, 5'd2, 5'd3, 4'b1111);
      #1 n_reset = 1'b0;
      #1;
      checkOutput("rst_beat_zero",
         32'({beat_valid, first_beat, last_beat, csr_write, illegal, apu_rvalid,
              vd_addr, vs2_addr, vs1_addr, lane_en}), 32'd0);
      checkOutput("rst_instr", instr | scalar_operand1 | scalar_operand2, 32'd0);
      checkOutput("rst_gnt", 32'(apu_gnt), 32'd1);
      @(posedge clk);
      #1 n_reset = 1'b1;
      busy_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (apu_rvalid || beat_valid) busy_seen++;
      end
      checkOutput("rst_no_rvalid", 32'(busy_seen), 32'd0);
      checkOutput("rst_perf", perf_beats | perf_stalls, 32'd0);

      // Performance counters: three beats with two stalled cycles on beat 1
      applyStimulus(opv(6'b000000, 3'b000, 5'd0, 5'd0, 5'd0), 32'd0, 32'd0);
      expectIdle("perf_wait", 1'b0);
      expectBeat("perf_b0", 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 4'b1111);
      @(posedge clk);
      #1 stall = 1'b1;
      expectBeat("perf_b1_stall", 1, 0, 0, 0, 0, 0, 5'd1, 5'd1, 5'd1, 4'b1111);
      @(posedge clk);
      @(posedge clk);
      #1 stall = 1'b0;
      expectBeat("perf_b1", 1, 0, 0, 0, 0, 0, 5'd1, 5'd1, 5'd1, 4'b1111);
      expectBeat("perf_b2", 1, 0, 1, 0, 0, 0, 5'd2, 5'd2, 5'd2, 4'b1111);
      expectIdle("perf_rvalid", 1'b1);
`ifdef VSEQ_PERF_EN
      checkOutput("perf_beats", perf_beats, 32'd3);
      checkOutput("perf_stalls", perf_stalls, 32'd2);
`else
      checkOutput("perf_beats", perf_beats, 32'd0);
      checkOutput("perf_stalls", perf_stalls, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
